bcd_chain_counter: RTL

Parametrised multi-digit BCD counter chain, the general successor to the fixed two-digit cascade used in the stopwatch datapath. Each digit has its own rollover limit, for example mm:ss as 5-9-5-9. Adds up/down counting, synchronous clear, parallel load, wrap or saturate mode, a cascadable terminal-count output and a sticky overflow flag. Sits between the tick prescaler and the display multiplexer, and can chain into a further instance through done.

---
 rtl/bcd_chain_counter.sv | 93 +++++++++
 1 files changed

// File: rtl/bcd_chain_counter.sv
// Multi-digit BCD counter chain. Each digit has its own rollover limit, and the
// chain supports up/down counting, clear, load, wrap-or-saturate and sticky overflow.
module bcd_chain_counter #(
  parameter int unsigned DIGITS = 4,
  parameter logic [31:0] LIMITS = 32'h0000_5959,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0]      count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DIGITS-1:0] terminal;
  logic [DIGITS-1:0] step_en;
  logic              all_term;

  // A digit is terminal at its limit going up, or at zero going down. A digit
  // only steps when every digit below it is terminal.
  always_comb begin
    terminal = '0;
    step_en  = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      terminal[i] = up ? (count_q[4*i +: 4] == LIMITS[4*i +: 4])
                       : (count_q[4*i +: 4] == 4'd0);
    end
    step_en[0] = 1'b1;
    for (int i = 1; i < int'(DIGITS); i++) begin
      step_en[i] = step_en[i-1] & terminal[i-1];
    end
  end

  assign all_term = &terminal;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the if/else tree can infer a latch.
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (load) begin
      // Clamping to the limit also covers non-BCD nibbles, since every limit is at most 9.
      for (int i = 0; i < int'(DIGITS); i++) begin
        count_d[4*i +: 4] = (load_value[4*i +: 4] > LIMITS[4*i +: 4]) ? LIMITS[4*i +: 4]
                                                                      : load_value[4*i +: 4];
      end
      overflow_d = 1'b0;
    end else if (enable) begin
      if (all_term) begin
        overflow_d = 1'b1;
      end
      if (WRAP || !all_term) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (step_en[i]) begin
            if (up) begin
              count_d[4*i +: 4] = terminal[i] ? 4'd0 : count_q[4*i +: 4] + 4'd1;
            end else begin
              count_d[4*i +: 4] = terminal[i] ? LIMITS[4*i +: 4] : count_q[4*i +: 4] - 4'd1;
            end
          end
        end
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  // Gated by reset_n, so a downstream instance never sees a stray enable during reset.
  assign done     = enable & ~clear & ~load & reset_n & all_term;

endmodule
